ula_float: RTL and testbench
============================

ULA_FLOAT -- requirements
Module: ula_float

Interface
REQ-001 Parameter: N, default 27, operand width; product width is 2*N.
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: multiplicando  input  N  multiplicand, unsigned fixed point 1.(N-1) (bit N-1 integer, rest fraction).
REQ-005 Port: multiplicador  input  N  multiplier, same format as multiplicando.
REQ-006 Port: produto  output  2N  registered unsigned product, format 2.(2N-2).

Function
REQ-007 The block SHALL compute the exact unsigned product multiplicando*multiplicador, with no rounding, truncation or normalisation.
- Bit-pattern product, e.g. 1.5*1.5 = 2.25 -> produto[53:50]=1001, rest 0.
REQ-008 The block SHALL use an iterative shift-add datapath, one multiplier bit per clock.
REQ-009 The FSM SHALL have states LOAD, RUN and DONE.
REQ-010 In LOAD, on one edge it SHALL:
- capture both operands into internal registers;
- clear the 2N-bit accumulator and the bit counter;
- go to RUN.
REQ-011 In RUN, on each edge it SHALL:
- add the captured multiplicand to the accumulator upper half if the current multiplier LSB is 1;
- shift accumulator/multiplier right by one;
- increment the counter.
REQ-012 After exactly N RUN edges, the FSM SHALL move to DONE and load produto with the accumulator on that same edge.
REQ-013 Latency: produto SHALL be valid after N+1 rising edges following reset deassertion (28 edges for N=27).
REQ-014 In DONE, produto SHALL hold its value; if either input differs from its captured copy, the FSM SHALL go to LOAD on the next edge.
REQ-015 Input changes during LOAD/RUN SHALL NOT affect the running computation; they are detected in DONE and trigger a recomputation.
REQ-016 During recomputation, produto SHALL keep the previous result until the new DONE edge.
REQ-017 The accumulator add SHALL carry into a bit N of the upper half so no carry is lost; maximum product (2^N-1)^2 is representable.

Reset
REQ-018 While reset is high, regardless of clock:
- state = LOAD;
- produto, accumulator, captured operands and counter = 0.
REQ-019 Reset asserted mid-RUN SHALL abort the computation immediately; after release, computation restarts from LOAD with the current inputs.

Structure
REQ-020 Package ula_float_pkg SHALL hold the width constant N, the counter width (clog2(N+1)) and the state enum {LOAD, RUN, DONE}.
REQ-021 The FSM and counter SHALL be a sub-module ula_float_ctrl; the accumulator and shift datapath SHALL stay in ula_float.

Verification
REQ-022 Reset at t=0, A=B=27'b11 followed by 25 zeros (1.5), release at 10ns -> produto=0 before 28 edges; 54'h24_0000_0000_0000 from edge 28, held through 1000ns.
REQ-023 A=B=27'h400_0000 (1.0) -> produto=54'h10_0000_0000_0000 after 28 edges.
REQ-024 A=0, B=27'h7FF_FFFF -> produto=0; then A=B=27'h7FF_FFFF -> produto=54'h3F_FFFF_F000_0001 (2^54-2^28+1) 29 edges after the change.
REQ-025 Change A mid-RUN at edge 10 -> old result held; the result for the new A appears 29 edges after DONE is first reached.
REQ-026 Assert reset at edge 15 of a run -> produto=0 immediately; after release, the correct product appears after 28 edges.

Source files
------------

// File: rtl/ula_float_pkg.sv
// Shared constants and state encoding for the iterative fixed-point multiplier.
package ula_float_pkg;
  localparam int N     = 27;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/ula_float_ctrl.sv
// Sequencer for the shift-add multiplier: LOAD -> N RUN steps -> DONE, and back
// to LOAD when the operands move away from the captured copies.
module ula_float_ctrl #(
  parameter int N  = ula_float_pkg::N,
  parameter int CW = $clog2(N + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  differ,
  output ula_float_pkg::state_t state,
  output logic                  last
);
  import ula_float_pkg::*;

  state_t        state_nxt;
  logic [CW-1:0] cnt;

  assign last = (state == RUN) && (cnt == CW'(N - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= LOAD;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == LOAD) cnt <= '0;
      else if (state == RUN) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (differ) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end
endmodule

// File: rtl/ula_float.sv
// Exact unsigned 1.(N-1) x 1.(N-1) -> 2.(2N-2) multiplier, one multiplier bit per clock.
// The previous product stays on produto until the next computation completes.
module ula_float #(
  parameter int N = ula_float_pkg::N
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   multiplicando,
  input  logic [N-1:0]   multiplicador,
  output logic [2*N-1:0] produto
);
  import ula_float_pkg::*;

  state_t         state;
  logic           last;
  logic           differ;
  logic [N-1:0]   a_cap;
  logic [N-1:0]   b_cap;
  logic [N-1:0]   mplier;
  logic [2*N-1:0] acc;
  logic [N:0]     sum;
  logic [2*N-1:0] acc_nxt;

  assign differ = (multiplicando != a_cap) || (multiplicador != b_cap);

  // The carry out of the upper-half add lands in the MSB after the shift.
  assign sum     = {1'b0, acc[2*N-1:N]} + (mplier[0] ? {1'b0, a_cap} : {(N+1){1'b0}});
  assign acc_nxt = {sum, acc[N-1:1]};

  ula_float_ctrl #(.N(N)) u_ctrl (
    .clock  (clock),
    .reset  (reset),
    .differ (differ),
    .state  (state),
    .last   (last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_cap   <= '0;
      b_cap   <= '0;
      mplier  <= '0;
      acc     <= '0;
      produto <= '0;
    end else begin
      case (state)
        LOAD: begin
          a_cap  <= multiplicando;
          b_cap  <= multiplicador;
          mplier <= multiplicador;
          acc    <= '0;
        end
        RUN: begin
          acc    <= acc_nxt;
          mplier <= mplier >> 1;
          if (last) produto <= acc_nxt;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ula_float.sv
// Directed bench for ula_float: latency, hold, recompute-on-change and mid-run reset.
module tb_ula_float;
  localparam int N = 27;

  localparam logic [N-1:0]   ONE_HALF = 27'h600_0000;
  localparam logic [N-1:0]   ONE      = 27'h400_0000;
  localparam logic [N-1:0]   MAXV     = 27'h7FF_FFFF;
  localparam logic [2*N-1:0] P_225    = 54'h24_0000_0000_0000;
  localparam logic [2*N-1:0] P_1      = 54'h10_0000_0000_0000;
  localparam logic [2*N-1:0] P_15     = 54'h18_0000_0000_0000;
  localparam logic [2*N-1:0] P_MAX    = 54'h3F_FFFF_F000_0001;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   multiplicando;
  logic [N-1:0]   multiplicador;
  logic [2*N-1:0] produto;

  int total = 0;
  int bad   = 0;

  ula_float #(.N(N)) dut (
    .clock         (clock),
    .reset         (reset),
    .multiplicando (multiplicando),
    .multiplicador (multiplicador),
    .produto       (produto)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [2*N-1:0] exp);
    total++;
    assert (produto === exp)
    else begin
      bad++;
      $error("FAIL %s: produto=%h expected=%h", tag, produto, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    multiplicando = ONE_HALF;
    multiplicador = ONE_HALF;
    #3;
    check("reset_zero", '0);
    #7;
    reset = 1'b0;

    // 1.5 * 1.5 from reset release: valid at edge 28, not before
    edges(27);
    check("lat_edge27", '0);
    edges(1);
    check("lat_edge28", P_225);
    #600;
    check("hold_600ns", P_225);
    #130;
    check("hold_1000ns", P_225);

    // 1.0 * 1.0, change applied while in DONE
    multiplicando = ONE;
    multiplicador = ONE;
    edges(28);
    check("one_old_held", P_225);
    edges(1);
    check("one_new", P_1);

    // zero operand
    multiplicando = '0;
    multiplicador = MAXV;
    edges(29);
    check("zero_prod", '0);

    // maximum operands, carry out of the upper half
    multiplicando = MAXV;
    multiplicador = MAXV;
    edges(28);
    check("max_old_held", '0);
    edges(1);
    check("max_prod", P_MAX);

    // mid-run change: 1.0*1.0 starts, A switches to 1.5 ten edges in
    multiplicando = ONE;
    multiplicador = ONE;
    edges(10);
    multiplicando = ONE_HALF;
    edges(18);
    check("midrun_before_done", P_MAX);
    edges(1);
    check("midrun_old_result", P_1);
    edges(28);
    check("midrun_recompute_held", P_1);
    edges(1);
    check("midrun_new_result", P_15);

    // reset at edge 15 of a 1.5*1.5 run
    multiplicador = ONE_HALF;
    edges(15);
    reset = 1'b1;
    #1;
    check("rst_immediate", '0);
    edges(1);
    check("rst_held", '0);
    reset = 1'b0;
    edges(27);
    check("rst_edge27", '0);
    edges(1);
    check("rst_edge28", P_225);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
